slc3_control_unit: RTL
======================

Name: slc3_control_unit

Overview:
- Instruction-sequencing FSM for the SLC-3 processor. It sits directly upstream of the datapath.
- Consumes the opcode and mode bits of IR, plus BEN, from the datapath.
- Drives every datapath load enable, bus gate and mux select, and the memory strobes.
- Runs a fetch / decode / execute cycle for the supported subset: ADD, AND, NOT, BR, JMP, JSR, LDR, STR, PAUSE.

Parameters:
MEM_WAIT, 2, cycles the memory read/write state is held with strobes asserted (1..7)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high; forces state Halted
Run  in  1  start pulse; leaves Halted
Continue  in  1  resume from PAUSE
Opcode  in  4  IR[15:12]
IR_5  in  1  IR[5], ADD/AND immediate select
IR_11  in  1  IR[11], JSR vs JSRR
BEN  in  1  branch enable from datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle
PCMUX  out  2  00 PC+1, 01 bus, 10 adder
DRMUX  out  1  0 IR[11:9], 1 R7
SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
SR2MUX  out  1  0 register SR2, 1 sext imm5
ADDR1MUX  out  1  0 PC, 1 SR1
ADDR2MUX  out  2  00 zero, 01 sext off11, 10 sext off9, 11 sext off6
ALUK  out  2  00 ADD, 01 AND, 10 NOT A, 11 pass A
MIO_EN  out  1  MDR loads from memory instead of bus
Mem_OE  out  1  memory read strobe, active-high
Mem_WE  out  1  memory write strobe, active-high

Behaviour:
Clocking and outputs
- Single clock. Reset is synchronous, active-high, and name-fixed as Clk/Reset.
- State register plus a wait counter of width clog2(MEM_WAIT+1).
- Moore outputs decoded from the current state only. Every output defaults to 0, and all outputs are 0 in Halted and during Reset.

Fetch and decode
- Halted: stays until Run=1, then goes to S18.
- S18: GatePC, LD_MAR, PCMUX=00, LD_PC. Next S33.
- S33 (read): Mem_OE=1, MIO_EN=1 for MEM_WAIT cycles. LD_MDR=1 on the final cycle only. Next S35.
- S35: GateMDR, LD_IR. Next S32.
- S32: LD_BEN. Branches on Opcode:
  - 0001 ADD → S01
  - 0101 AND → S05
  - 1001 NOT → S09
  - 0000 BR → S00
  - 1100 JMP → S12
  - 0100 JSR → S04
  - 0110 LDR → S06
  - 0111 STR → S07
  - 1101 PAUSE → P1
  - any other opcode → S18 (treated as NOP)
- Fetch+decode latency is MEM_WAIT+3 cycles: 5 at the default.

Execute
- S01/S05: SR1MUX=1, SR2MUX=IR_5, ALUK=00 or 01, GateALU, DRMUX=0, LD_REG, LD_CC. Next S18.
- S09: SR1MUX=1, ALUK=10, GateALU, DRMUX=0, LD_REG, LD_CC. Next S18.
- S00: BEN=1 → S22, otherwise → S18. BEN is sampled as registered in S32.
- S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC. Next S18.
- S12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC. Next S18.
- S04: GatePC, DRMUX=1, LD_REG (R7 ← PC). Next S21.
- S21: IR_11=1 uses ADDR1MUX=0, ADDR2MUX=01; IR_11=0 uses ADDR1MUX=1, SR1MUX=1, ADDR2MUX=00. Both use PCMUX=10, LD_PC. Next S18.
- S06/S07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=11, GateMARMUX, LD_MAR. Next S25 (LDR) or S23 (STR).
- S25: same as S33 (read, MEM_WAIT cycles). Next S27.
- S27: GateMDR, DRMUX=0, LD_REG, LD_CC. Next S18.
- S23: SR1MUX=0, ALUK=11, GateALU, LD_MDR, MIO_EN=0. Next S16.
- S16: Mem_WE=1 for MEM_WAIT cycles. Next S18.
- P1: LD_LED=1. Stays while Continue=0; Continue=1 → P2.
- P2: waits for Continue=0, then → S18. This stops a held Continue from skipping a second PAUSE.

Boundary and timing rules
- Run is ignored outside Halted. Continue is ignored outside P1/P2.
- The wait counter clears on every state entry.
- Reset at any cycle, including mid-memory-wait, gives Halted on the next edge with all strobes deasserted.
- Invariant: Gate signals are one-hot or zero, and Mem_OE and Mem_WE are never both high.

Decomposition:
- Package slc3_pkg holds:
  - state enum
  - opcode localparams (OP_ADD etc.)
  - PCMUX, ADDR2MUX and ALUK encodings
- The datapath and this block both import slc3_pkg.
- No sub-module. The wait counter stays inline.

Test Plan:
- Reset for 2 cycles, Run=0 → state Halted, all outputs 0 for 10 cycles.
- Run pulse, Opcode=0001, IR_5=1, MEM_WAIT=2 → S18, S33×2 (LD_MDR on 2nd only), S35, S32, S01 (SR2MUX=1, LD_REG, LD_CC), S18 at cycle 7.
- BR with BEN=0 → S32, S00, S18. With BEN=1 → S00, S22 (PCMUX=10, ADDR2MUX=10), S18.
- LDR → S06 (ADDR2MUX=11, GateMARMUX), S25 Mem_OE for 2 cycles, S27 LD_REG. Reset asserted in 1st S25 cycle → Halted next edge, Mem_OE=0.
- PAUSE with Continue held 1 across P1 → P2 holds until Continue=0. LD_LED high only in P1.
- JSR with IR_11=0 → S04 (DRMUX=1, GatePC, LD_REG), S21 (ADDR1MUX=1, ADDR2MUX=00, PCMUX=10). Every cycle checks gate one-hot and !(Mem_OE&&Mem_WE).

Source files
------------

// File: rtl/slc3_pkg.sv
// slc3_pkg: shared definitions for the SLC-3 control unit and datapath.
//   - state_t : control FSM state encoding
//   - OP_*    : IR[15:12] opcodes of the supported instruction subset
//   - PCMUX_*, ADDR2_*, ALUK_* : datapath mux / ALU select encodings
package slc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED,
    S_18,
    S_33,
    S_35,
    S_32,
    S_01,
    S_05,
    S_09,
    S_00,
    S_22,
    S_12,
    S_04,
    S_21,
    S_06,
    S_07,
    S_25,
    S_27,
    S_23,
    S_16,
    S_P1,
    S_P2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF11 = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF6  = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOTA  = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage

// File: rtl/slc3_control_unit.sv
// slc3_control_unit: fetch / decode / execute sequencer for the SLC-3.
//   Inputs : Clk, Reset (sync, active-high), Run, Continue,
//            Opcode (IR[15:12]), IR_5, IR_11, BEN
//   Outputs: register loads (LD_*), bus gates (Gate*), mux selects
//            (PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK),
//            MIO_EN and the memory strobes Mem_OE / Mem_WE.
//   Outputs are a decode of the registered state (plus the wait counter
//   in memory states) and are forced low while Reset is high.
module slc3_control_unit
  import slc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_WAIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             wait_last;
  logic             in_mem_state;

  assign wait_last    = (wait_cnt_q == LAST_CNT);
  assign in_mem_state = (state_q == S_33) || (state_q == S_25) || (state_q == S_16);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_HALTED;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALTED: if (Run) state_d = S_18;
      S_18:     state_d = S_33;
      S_33:     if (wait_last) state_d = S_35;
      S_35:     state_d = S_32;
      S_32: begin
        unique case (Opcode)
          OP_ADD:   state_d = S_01;
          OP_AND:   state_d = S_05;
          OP_NOT:   state_d = S_09;
          OP_BR:    state_d = S_00;
          OP_JMP:   state_d = S_12;
          OP_JSR:   state_d = S_04;
          OP_LDR:   state_d = S_06;
          OP_STR:   state_d = S_07;
          OP_PAUSE: state_d = S_P1;
          default:  state_d = S_18;
        endcase
      end
      S_00:     state_d = BEN ? S_22 : S_18;
      S_04:     state_d = S_21;
      S_06:     state_d = S_25;
      S_07:     state_d = S_23;
      S_25:     if (wait_last) state_d = S_27;
      S_23:     state_d = S_16;
      S_16:     if (wait_last) state_d = S_18;
      S_P1:     if (Continue) state_d = S_P2;
      // P2 waits for Continue to drop so a held Continue cannot pass a
      // following PAUSE as well.
      S_P2:     if (!Continue) state_d = S_18;
      S_01, S_05, S_09, S_22, S_12, S_21, S_27: state_d = S_18;
      default:  state_d = S_HALTED;
    endcase

    // Counter only advances while dwelling in a memory state; any state
    // change (including re-entry) starts it from zero.
    wait_cnt_d = '0;
    if (in_mem_state && (state_d == state_q)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  // Output decode
  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_PC1;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    ALUK       = ALUK_ADD;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        S_18: begin
          GatePC = 1'b1;
          LD_MAR = 1'b1;
          PCMUX  = PCMUX_PC1;
          LD_PC  = 1'b1;
        end
        S_33, S_25: begin
          Mem_OE = 1'b1;
          MIO_EN = 1'b1;
          LD_MDR = wait_last;
        end
        S_35: begin
          GateMDR = 1'b1;
          LD_IR   = 1'b1;
        end
        S_32: LD_BEN = 1'b1;
        S_01, S_05: begin
          SR1MUX  = 1'b1;
          SR2MUX  = IR_5;
          ALUK    = (state_q == S_05) ? ALUK_AND : ALUK_ADD;
          GateALU = 1'b1;
          LD_REG  = 1'b1;
          LD_CC   = 1'b1;
        end
        S_09: begin
          SR1MUX  = 1'b1;
          ALUK    = ALUK_NOTA;
          GateALU = 1'b1;
          LD_REG  = 1'b1;
          LD_CC   = 1'b1;
        end
        S_22: begin
          ADDR2MUX = ADDR2_OFF9;
          PCMUX    = PCMUX_ADDER;
          LD_PC    = 1'b1;
        end
        S_12: begin
          SR1MUX   = 1'b1;
          ADDR1MUX = 1'b1;
          PCMUX    = PCMUX_ADDER;
          LD_PC    = 1'b1;
        end
        S_04: begin
          GatePC = 1'b1;
          DRMUX  = 1'b1;
          LD_REG = 1'b1;
        end
        S_21: begin
          if (IR_11) begin
            ADDR2MUX = ADDR2_OFF11;
          end else begin
            ADDR1MUX = 1'b1;
            SR1MUX   = 1'b1;
          end
          PCMUX = PCMUX_ADDER;
          LD_PC = 1'b1;
        end
        S_06, S_07: begin
          SR1MUX     = 1'b1;
          ADDR1MUX   = 1'b1;
          ADDR2MUX   = ADDR2_OFF6;
          GateMARMUX = 1'b1;
          LD_MAR     = 1'b1;
        end
        S_27: begin
          GateMDR = 1'b1;
          LD_REG  = 1'b1;
          LD_CC   = 1'b1;
        end
        S_23: begin
          ALUK    = ALUK_PASSA;
          GateALU = 1'b1;
          LD_MDR  = 1'b1;
        end
        S_16: Mem_WE = 1'b1;
        S_P1: LD_LED = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
